// File: rtl/digit_entry_if.sv
// rtl/digit_entry_if.sv - front-panel key inputs and display/vote outputs of digit_entry
interface digit_entry_if #(
  parameter int NUM_DIGITS = 2
);
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    key_inc;
  logic                    key_next;
  logic                    key_confirm;
  logic                    key_clear;
  logic [CW-1:0]           cursor;
  logic                    locked;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [7*NUM_DIGITS-1:0] hex;
  logic                    vote_valid;
  logic [4*NUM_DIGITS-1:0] vote_value;

  modport master (
    output key_inc, key_next, key_confirm, key_clear,
    input  cursor, locked, bcd, hex, vote_valid, vote_value
  );

  modport slave (
    input  key_inc, key_next, key_confirm, key_clear,
    output cursor, locked, bcd, hex, vote_valid, vote_value
  );
endinterface

// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - N-digit BCD entry with debounced keys, 7-seg drive and vote capture
module digit_entry #(
  parameter int NUM_DIGITS      = 2,
  parameter int MAX_DIGIT       = 9,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  digit_entry_if.slave bus
);
  localparam int CW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {ENTRY, LOCKED} state_t;

  // key order everywhere: {clear, confirm, next, inc}
  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       deb;
  logic [3:0]       press;
  logic [CNT_W-1:0] cnt [4];

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [CW-1:0]           cur;
  logic                    vv;
  logic [4*NUM_DIGITS-1:0] vval;
  logic [3:0]              cur_digit;
  logic [7*NUM_DIGITS-1:0] hex_c;

  assign raw = {bus.key_clear, bus.key_confirm, bus.key_next, bus.key_inc};

  // press is registered on the same edge the debounced level falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      press <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]   <= sync2[i];
          cnt[i]   <= '0;
          press[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cur_digit = bcd_q[int'(cur)*4 +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ENTRY;
      bcd_q <= '0;
      cur   <= '0;
      vv    <= 1'b0;
      vval  <= '0;
    end else begin
      vv <= 1'b0;
      if (state == ENTRY) begin
        if (press[3]) begin
          bcd_q <= '0;
          cur   <= '0;
        end else if (press[2]) begin
          vval  <= bcd_q;
          vv    <= 1'b1;
          state <= LOCKED;
        end else if (press[1]) begin
          cur <= (cur == CW'(NUM_DIGITS - 1)) ? '0 : cur + 1'b1;
        end else if (press[0]) begin
          bcd_q[int'(cur)*4 +: 4] <= (cur_digit == 4'(MAX_DIGIT)) ? 4'd0 : cur_digit + 4'd1;
        end
      end else begin
        if (press[3]) begin
          bcd_q <= '0;
          cur   <= '0;
          state <= ENTRY;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    hex_c = '1;
    for (int i = 0; i < NUM_DIGITS; i++) hex_c[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
  end

  assign bus.cursor     = cur;
  assign bus.locked     = (state == LOCKED);
  assign bus.bcd        = bcd_q;
  assign bus.hex        = hex_c;
  assign bus.vote_valid = vv;
  assign bus.vote_value = vval;
endmodule
